if_id_pipe_reg: RTL and testbench

//  Receiving end of the IF2ID interface: registers the IF stage's pc/instruction/pc_plus4 bundle for decode.

---
 rtl/core_pkg.sv | 17 +
 rtl/IF2ID_if.sv | 7 +
 rtl/sat_counter.sv | 19 +
 rtl/if_id_pipe_reg.sv | 47 ++++
 tb/tb_if_id_pipe_reg.sv | 119 +++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared IF/ID pipeline types, FSM state encoding and the default NOP encoding.
package core_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
      logic [31:0] pc_plus4;
   } if_id_data_t;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_VALID  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_BUBBLE = 2'd3
   } ifid_state_e;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
endpackage

// File: rtl/IF2ID_if.sv
// IF2ID_if: fetch-to-decode bundle; IF drives as MASTER, the IF/ID register receives as SLAVE.
interface IF2ID_if;
   import core_pkg::*;
   if_id_data_t data;
   modport MASTER (output data);
   modport SLAVE  (input  data);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

   assign cnt_o = cnt_q;
endmodule

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register with stall hold, flush bubble and validity FSM
module if_id_pipe_reg
  import core_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  IF2ID_if.SLAVE      bus_in,
  output if_id_data_t data_o,
  output logic        valid_o,
  output logic [1:0]  state_o
`ifdef IFID_PERF_CNT_EN
  , output logic [PERF_CNT_WIDTH-1:0] stall_cnt_o
  , output logic [PERF_CNT_WIDTH-1:0] flush_cnt_o
`endif
);
  ifid_state_e state_q, state_d;
  if_id_data_t data_q, data_d;
  logic valid_q, valid_d;
  always_comb begin
    state_d = flush_i ? ST_BUBBLE : stall_i ? ((state_q == ST_VALID) ? ST_HOLD : state_q) : ST_VALID;
    data_d  = flush_i ? '{pc: bus_in.data.pc, instruction: NOP_INSTR, pc_plus4: bus_in.data.pc_plus4}
            : stall_i ? data_q : bus_in.data;
    valid_d = (state_d == ST_VALID) || (state_d == ST_HOLD);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '{pc: 32'd0, instruction: NOP_INSTR, pc_plus4: 32'd0};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign state_o = state_q;
`ifdef IFID_PERF_CNT_EN
  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc_i(stall_i && !flush_i), .cnt_o(stall_cnt_o));
  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc_i(flush_i), .cnt_o(flush_cnt_o));
`endif
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed checks of reset, streaming, stall, flush and flush+stall priority
module tb_if_id_pipe_reg;
  import core_pkg::*;
  logic clk = 1'b0;
  logic rst_n, stall_i, flush_i;
  if_id_data_t data_o;
  logic valid_o;
  logic [1:0] state_o;
  int checks = 0, failures = 0;
  logic [3:0] stall_cnt_o, flush_cnt_o;
  IF2ID_if bus ();
  always #5 clk = ~clk;
  if_id_pipe_reg #(.PERF_CNT_WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .bus_in  (bus),
    .data_o  (data_o),
    .valid_o (valid_o),
    .state_o (state_o)
`ifdef IFID_PERF_CNT_EN
    , .stall_cnt_o (stall_cnt_o)
    , .flush_cnt_o (flush_cnt_o)
`endif
  );
  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    bus.data = '{pc: pc, instruction: ins, pc_plus4: pc + 32'd4};
  endtask
  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic v, input logic [1:0] st);
    check({tag, "_data"}, data_o, {pc, ins, pc + 32'd4});
    check({tag, "_valid"}, {95'd0, valid_o}, {95'd0, v});
    check({tag, "_state"}, {94'd0, state_o}, {94'd0, st});
  endtask
  task automatic expect_reset(input string tag);
    check({tag, "_data"}, data_o, {32'd0, 32'h13, 32'd0});
    check({tag, "_valid"}, {95'd0, valid_o}, 96'd0);
    check({tag, "_state"}, {94'd0, state_o}, 96'd0);
  endtask
  initial begin
    rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(32'h100, 32'hDEAD_BEEF);
    #3 rst_n = 1'b0;
    #1 expect_reset("reset_async");
    step();
    step();
    expect_reset("reset_held");
    rst_n = 1'b1;
    drive(32'h0, 32'hAAAA_0001);
    step(); expect_out("stream0", 32'h0, 32'hAAAA_0001, 1'b1, 2'd1);
    drive(32'h4, 32'hBBBB_0002);
    step(); expect_out("stream4", 32'h4, 32'hBBBB_0002, 1'b1, 2'd1);
    drive(32'h8, 32'hCCCC_0003);
    step(); expect_out("stream8", 32'h8, 32'hCCCC_0003, 1'b1, 2'd1);
    stall_i = 1'b1;
    drive(32'hC, 32'hDDDD_0004);
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("stall_hold", 32'h8, 32'hCCCC_0003, 1'b1, 2'd2);
    end
    stall_i = 1'b0;
    drive(32'h8, 32'hCCCC_0003);
    step(); expect_out("stall_release", 32'h8, 32'hCCCC_0003, 1'b1, 2'd1);
    drive(32'hC, 32'hDDDD_0004);
    step(); expect_out("after_stall", 32'hC, 32'hDDDD_0004, 1'b1, 2'd1);
    flush_i = 1'b1;
    drive(32'h10, 32'hEEEE_0005);
    step(); expect_out("flush", 32'h10, 32'h13, 1'b0, 2'd3);
    flush_i = 1'b0;
    drive(32'h40, 32'hFFFF_0006);
    step(); expect_out("flush_target", 32'h40, 32'hFFFF_0006, 1'b1, 2'd1);
    flush_i = 1'b1; stall_i = 1'b1;
    drive(32'h50, 32'h1111_0007);
    step(); expect_out("flush_stall", 32'h50, 32'h13, 1'b0, 2'd3);
    flush_i = 1'b0;
    drive(32'h60, 32'h2222_0008);
    step(); expect_out("bubble_stall", 32'h50, 32'h13, 1'b0, 2'd3);
    stall_i = 1'b0;
    step(); expect_out("bubble_exit", 32'h60, 32'h2222_0008, 1'b1, 2'd1);
    stall_i = 1'b1;
    step(); expect_out("pre_reset_hold", 32'h60, 32'h2222_0008, 1'b1, 2'd2);
    #2 rst_n = 1'b0;
    #1 expect_reset("reset_mid_stall");
    step();
    rst_n = 1'b1;
    step(); expect_reset("empty_stall");
    stall_i = 1'b0;
    step(); expect_out("empty_exit", 32'h60, 32'h2222_0008, 1'b1, 2'd1);
`ifdef IFID_PERF_CNT_EN
    rst_n = 1'b0;
    #1 check("cnt_reset_stall", {92'd0, stall_cnt_o}, 96'd0);
    check("cnt_reset_flush", {92'd0, flush_cnt_o}, 96'd0);
    step();
    rst_n = 1'b1;
    stall_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("cnt_stall_sat", {92'd0, stall_cnt_o}, {92'd0, 4'hF});
    stall_i = 1'b0; flush_i = 1'b1;
    step(); step();
    flush_i = 1'b0;
    step();
    check("cnt_flush", {92'd0, flush_cnt_o}, {92'd0, 4'd2});
    check("cnt_stall_kept", {92'd0, stall_cnt_o}, {92'd0, 4'hF});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
